// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Handles misses for a 4-way set-associative cache. It picks a victim way,
//   writes the victim back to DFP memory if it is dirty, and fetches the
//   missing line. It then installs the line in the data and tag arrays and
//   issues the LRU update for the filled way.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   miss_req/_addr    miss from the lookup stage; held with stable inputs
//                     until miss_ack
//   evict_way         PLRU victim for the indexed set
//   way_valid/_dirty  per-way valid and dirty bits of the indexed set
//   way_tag           per-way tags of the indexed set, way0 in the LSBs
//   miss_ack          one-cycle pulse once the line is installed
//   data_*            data array read/write port (read data is valid the
//                     cycle after data_rd_en)
//   meta_wr_en/_tag   tag write; the array sets valid=1, dirty=0
//   lru_update        one-cycle LRU write for data_set / lru_access_way
//   dfp_*             memory port; dfp_resp is a one-cycle completion
//
// Handshake: miss_req is sampled only in IDLE. The requester keeps it and
// the set-side inputs stable until the cycle of miss_ack. A miss_req that is
// still high in the IDLE cycle after miss_ack starts a new miss.
module cache_refill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int SET_W  = 4,
    parameter int OFS_W  = 5,
    parameter int TAG_W  = ADDR_W - SET_W - OFS_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 miss_req,
    input  logic [ADDR_W-1:0]    miss_addr,
    input  logic [1:0]           evict_way,
    input  logic [3:0]           way_valid,
    input  logic [3:0]           way_dirty,
    input  logic [4*TAG_W-1:0]   way_tag,
    output logic                 miss_ack,
    output logic                 data_rd_en,
    input  logic [LINE_W-1:0]    data_rdata,
    output logic                 data_wr_en,
    output logic [1:0]           data_way,
    output logic [SET_W-1:0]     data_set,
    output logic [LINE_W-1:0]    data_wdata,
    output logic                 meta_wr_en,
    output logic [TAG_W-1:0]     meta_tag,
    output logic                 lru_update,
    output logic [1:0]           lru_access_way,
    output logic [ADDR_W-1:0]    dfp_addr,
    output logic                 dfp_read,
    output logic                 dfp_write,
    output logic [LINE_W-1:0]    dfp_wdata,
    input  logic [LINE_W-1:0]    dfp_rdata,
    input  logic                 dfp_resp
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_VICTIM = 3'd1,
        S_WB_LATCH  = 3'd2,
        S_WRITEBACK = 3'd3,
        S_FILL      = 3'd4,
        S_INSTALL   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [SET_W-1:0]     set_q, set_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [TAG_W-1:0]     vtag_q, vtag_d;
    logic [1:0]           way_q, way_d;
    logic [LINE_W-1:0]    wb_buf_q, wb_buf_d;
    logic [LINE_W-1:0]    fill_buf_q, fill_buf_d;

    logic [1:0]           pick_way;
    logic                 pick_dirty;
    logic [TAG_W-1:0]     sel_tag;
    logic                 unused_ofs;

    // The line offset is implied zero on the memory side.
    assign unused_ofs = ^miss_addr[OFS_W-1:0];

    // An empty way is filled before anything is evicted. The lowest-index
    // invalid way wins. Only a full set falls back to the PLRU choice.
    always_comb begin
        pick_way = evict_way;
        casez (way_valid)
            4'b???0: pick_way = 2'd0;
            4'b??01: pick_way = 2'd1;
            4'b?011: pick_way = 2'd2;
            4'b0111: pick_way = 2'd3;
            default: pick_way = evict_way;
        endcase
        pick_dirty = way_valid[pick_way] & way_dirty[pick_way];
    end

    // Tag of the latched way. It is used to build the writeback address.
    always_comb begin
        sel_tag = way_tag[0 +: TAG_W];
        case (way_q)
            2'd0: sel_tag = way_tag[0*TAG_W +: TAG_W];
            2'd1: sel_tag = way_tag[1*TAG_W +: TAG_W];
            2'd2: sel_tag = way_tag[2*TAG_W +: TAG_W];
            2'd3: sel_tag = way_tag[3*TAG_W +: TAG_W];
            default: sel_tag = way_tag[0 +: TAG_W];
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (miss_req) begin
                    state_d = pick_dirty ? S_RD_VICTIM : S_FILL;
                end
            end
            S_RD_VICTIM: state_d = S_WB_LATCH;
            S_WB_LATCH:  state_d = S_WRITEBACK;
            S_WRITEBACK: if (dfp_resp) state_d = S_FILL;
            S_FILL:      if (dfp_resp) state_d = S_INSTALL;
            S_INSTALL:   state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_comb begin
        set_d      = set_q;
        tag_d      = tag_q;
        vtag_d     = vtag_q;
        way_d      = way_q;
        wb_buf_d   = wb_buf_q;
        fill_buf_d = fill_buf_q;
        case (state_q)
            S_IDLE: begin
                if (miss_req) begin
                    set_d = miss_addr[OFS_W +: SET_W];
                    tag_d = miss_addr[ADDR_W-1 -: TAG_W];
                    way_d = pick_way;
                end
            end
            S_RD_VICTIM: vtag_d   = sel_tag;
            S_WB_LATCH:  wb_buf_d = data_rdata;
            S_FILL:      if (dfp_resp) fill_buf_d = dfp_rdata;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_q      <= '0;
            tag_q      <= '0;
            vtag_q     <= '0;
            way_q      <= '0;
            wb_buf_q   <= '0;
            fill_buf_q <= '0;
        end else begin
            set_q      <= set_d;
            tag_q      <= tag_d;
            vtag_q     <= vtag_d;
            way_q      <= way_d;
            wb_buf_q   <= wb_buf_d;
            fill_buf_q <= fill_buf_d;
        end
    end

    // ---------------- FSM: outputs ----------------
    // Strobes decode straight from state_q. An asynchronous reset therefore
    // drops dfp_read/dfp_write in the same instant the state returns to IDLE.
    always_comb begin
        data_rd_en     = (state_q == S_RD_VICTIM);
        dfp_write      = (state_q == S_WRITEBACK);
        dfp_read       = (state_q == S_FILL);
        miss_ack       = (state_q == S_INSTALL);
        data_wr_en     = (state_q == S_INSTALL);
        meta_wr_en     = (state_q == S_INSTALL);
        lru_update     = (state_q == S_INSTALL);
        data_way       = way_q;
        data_set       = set_q;
        lru_access_way = way_q;
        meta_tag       = tag_q;
        data_wdata     = fill_buf_q;
        dfp_wdata      = wb_buf_q;
        if (state_q == S_WRITEBACK) begin
            dfp_addr = {vtag_q, set_q, {OFS_W{1'b0}}};
        end else begin
            dfp_addr = {tag_q, set_q, {OFS_W{1'b0}}};
        end
    end

endmodule
